// File: rtl/obi_wb_bridge.sv
// OBI to Wishbone classic bridge: one outstanding transfer,
// registered bus cycle, bus-error response on ack timeout.
module obi_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_wstrb_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          hs;
  logic          tmo;

  assign obi_gnt_o    = obi_req_i & (state != S_BUS);
  assign hs           = obi_req_i & obi_gnt_o;
  assign wb_cyc_o     = (state == S_BUS);
  assign wb_stb_o     = wb_cyc_o;
  assign obi_rvalid_o = (state == S_RESP);

  // Timeout fires on the bus cycle that would bring the count to the limit.
  assign cnt_nxt = cnt + CW'(1);
  assign tmo     = (TIMEOUT_CYCLES != 0) &&
                   (cnt_nxt == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wb_addr_o   <= '0;
      wb_we_o     <= 1'b0;
      wb_wstrb_o  <= '0;
      wb_data_o   <= '0;
      obi_rdata_o <= '0;
      obi_err_o   <= 1'b0;
    end else begin
      case (state)
        S_BUS: begin
          if (wb_ack_i) begin
            obi_rdata_o <= wb_we_o ? 32'h0 : wb_data_i;
            obi_err_o   <= 1'b0;
            state       <= S_RESP;
          end else if (tmo) begin
            obi_rdata_o <= ERR_DATA;
            obi_err_o   <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          if (hs) begin
            wb_addr_o  <= obi_addr_i;
            wb_we_o    <= obi_we_i;
            wb_wstrb_o <= obi_be_i;
            wb_data_o  <= obi_we_i ? obi_wdata_i : 32'h0;
            cnt        <= '0;
            state      <= S_BUS;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Bench for obi_wb_bridge: transaction-level model checked every
// cycle plus directed vectors with literal expectations.
module tb_obi_wb_bridge;

  localparam int TMO = 4;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_wstrb_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  int n_chk  = 0;
  int n_fail = 0;

  obi_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_core    (clk_core),
    .rst_core    (rst_core),
    .obi_req_i   (obi_req_i),
    .obi_gnt_o   (obi_gnt_o),
    .obi_addr_i  (obi_addr_i),
    .obi_we_i    (obi_we_i),
    .obi_be_i    (obi_be_i),
    .obi_wdata_i (obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o),
    .obi_rdata_o (obi_rdata_o),
    .obi_err_o   (obi_err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_wstrb_o  (wb_wstrb_o),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Model: a transfer is either on the bus (with bus cycles served so
  // far) or answered; an answer is visible for the cycle after it.
  bit          m_busy, n_busy;
  bit          m_resp, n_resp;
  int          m_cnt, n_cnt;
  logic [31:0] m_addr, n_addr;
  bit          m_we, n_we;
  logic [3:0]  m_be, n_be;
  logic [31:0] m_wd, n_wd;
  logic [31:0] m_rd, n_rd;
  bit          m_err, n_err;

  always_comb begin
    n_busy = m_busy;
    n_resp = 1'b0;
    n_cnt  = m_cnt;
    n_addr = m_addr;
    n_we   = m_we;
    n_be   = m_be;
    n_wd   = m_wd;
    n_rd   = m_rd;
    n_err  = m_err;
    if (m_busy) begin
      n_cnt = m_cnt + 1;
      if (wb_ack_i) begin
        n_rd   = m_we ? 32'h0 : wb_data_i;
        n_err  = 1'b0;
        n_busy = 1'b0;
        n_resp = 1'b1;
      end else if (m_cnt + 1 == TMO) begin
        n_rd   = 32'hDEADBEEF;
        n_err  = 1'b1;
        n_busy = 1'b0;
        n_resp = 1'b1;
      end
    end
    if (obi_req_i && !m_busy) begin
      n_addr = obi_addr_i;
      n_we   = obi_we_i;
      n_be   = obi_be_i;
      n_wd   = obi_we_i ? obi_wdata_i : 32'h0;
      n_busy = 1'b1;
      n_cnt  = 0;
    end
  end

  always @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
      m_cnt  <= 0;
      m_addr <= '0;
      m_we   <= 1'b0;
      m_be   <= '0;
      m_wd   <= '0;
      m_rd   <= '0;
      m_err  <= 1'b0;
    end else begin
      m_busy <= n_busy;
      m_resp <= n_resp;
      m_cnt  <= n_cnt;
      m_addr <= n_addr;
      m_we   <= n_we;
      m_be   <= n_be;
      m_wd   <= n_wd;
      m_rd   <= n_rd;
      m_err  <= n_err;
    end
  end

  always @(negedge clk_core) begin
    chk("m_gnt", obi_gnt_o, obi_req_i && !m_busy);
    chk("m_cyc", wb_cyc_o, m_busy);
    chk("m_stb", wb_stb_o, wb_cyc_o);
    chk("m_rvalid", obi_rvalid_o, m_resp);
    chk("m_rdata", obi_rdata_o, m_rd);
    chk("m_err", obi_err_o, m_err);
    if (m_busy) begin
      chk("m_addr", wb_addr_o, m_addr);
      chk("m_we", wb_we_o, m_we);
      chk("m_wstrb", wb_wstrb_o, m_be);
      chk("m_wdata", wb_data_o, m_wd);
    end
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_core);
  endtask

  initial begin
    rst_core    = 1'b1;
    obi_req_i   = 1'b0;
    obi_addr_i  = '0;
    obi_we_i    = 1'b0;
    obi_be_i    = 4'hF;
    obi_wdata_i = '0;
    wb_data_i   = '0;
    wb_ack_i    = 1'b0;

    repeat (2) @(posedge clk_core);
    neg();
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_rvalid", obi_rvalid_o, 0);
    chk("rst_rdata", obi_rdata_o, 0);
    chk("rst_addr", wb_addr_o, 0);
    step(); rst_core = 1'b0;
    step();

    // read, ack on third bus cycle
    obi_req_i = 1'b1; obi_addr_i = 32'h100; obi_we_i = 1'b0;
    obi_wdata_i = 32'hAAAA5555;
    neg(); chk("rd_gnt", obi_gnt_o, 1);
    step(); obi_req_i = 1'b0;
    neg(); chk("rd_cyc1", wb_cyc_o, 1);
    chk("rd_addr", wb_addr_o, 32'h100);
    chk("rd_wdata0", wb_data_o, 0);
    step(); neg(); chk("rd_cyc2", wb_cyc_o, 1);
    step(); wb_ack_i = 1'b1; wb_data_i = 32'hCAFEF00D;
    neg(); chk("rd_cyc3", wb_cyc_o, 1);
    step(); wb_ack_i = 1'b0; wb_data_i = '0;
    neg(); chk("rd_rvalid", obi_rvalid_o, 1);
    chk("rd_rdata", obi_rdata_o, 32'hCAFEF00D);
    chk("rd_err", obi_err_o, 0);
    chk("rd_cyc4", wb_cyc_o, 0);
    step(); neg(); chk("rd_pulse", obi_rvalid_o, 0);
    chk("rd_hold", obi_rdata_o, 32'hCAFEF00D);

    // write, ack on first bus cycle
    step(); obi_req_i = 1'b1; obi_addr_i = 32'h200;
    obi_we_i = 1'b1; obi_be_i = 4'b0011; obi_wdata_i = 32'h12345678;
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'hFFFFFFFF;
    neg(); chk("wr_we", wb_we_o, 1);
    chk("wr_strb", wb_wstrb_o, 4'b0011);
    chk("wr_data", wb_data_o, 32'h12345678);
    step(); wb_ack_i = 1'b0; obi_we_i = 1'b0; obi_be_i = 4'hF;
    neg(); chk("wr_rvalid", obi_rvalid_o, 1);
    chk("wr_rdata", obi_rdata_o, 0);

    // back-to-back reads with req held
    step(); obi_req_i = 1'b1; obi_addr_i = 32'h300;
    step(); wb_ack_i = 1'b1; wb_data_i = 32'h11111111;
    neg(); chk("b2b_nogntbus", obi_gnt_o, 0);
    step(); wb_ack_i = 1'b0; obi_addr_i = 32'h304;
    neg(); chk("b2b_rv1", obi_rvalid_o, 1);
    chk("b2b_gnt2", obi_gnt_o, 1);
    chk("b2b_gap", wb_cyc_o, 0);
    chk("b2b_rd1", obi_rdata_o, 32'h11111111);
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h22222222;
    neg(); chk("b2b_cyc2", wb_cyc_o, 1);
    chk("b2b_addr2", wb_addr_o, 32'h304);
    step(); wb_ack_i = 1'b0;
    neg(); chk("b2b_rd2", obi_rdata_o, 32'h22222222);
    chk("b2b_rv2", obi_rvalid_o, 1);

    // timeout, no ack
    step(); obi_req_i = 1'b1; obi_addr_i = 32'h400;
    step(); obi_req_i = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      neg(); chk($sformatf("to_cyc%0d", i), wb_cyc_o, 1);
      step();
    end
    neg(); chk("to_drop", wb_cyc_o, 0);
    chk("to_rvalid", obi_rvalid_o, 1);
    chk("to_err", obi_err_o, 1);
    chk("to_rdata", obi_rdata_o, 32'hDEADBEEF);
    step(); neg(); chk("to_errhold", obi_err_o, 1);
    chk("to_pulse", obi_rvalid_o, 0);

    // ack in the timeout cycle wins
    step(); obi_req_i = 1'b1; obi_addr_i = 32'h404;
    step(); obi_req_i = 1'b0;
    step(); step();
    step(); wb_ack_i = 1'b1; wb_data_i = 32'h5A5A5A5A;
    step(); wb_ack_i = 1'b0;
    neg(); chk("tw_rvalid", obi_rvalid_o, 1);
    chk("tw_err", obi_err_o, 0);
    chk("tw_rdata", obi_rdata_o, 32'h5A5A5A5A);

    // reset in the middle of a read
    step(); obi_req_i = 1'b1; obi_addr_i = 32'h500;
    step(); obi_req_i = 1'b0;
    neg(); chk("rs_cyc", wb_cyc_o, 1);
    step(); rst_core = 1'b1;
    #1;
    chk("rs_cyc_now", wb_cyc_o, 0);
    chk("rs_rv_now", obi_rvalid_o, 0);
    chk("rs_rdata", obi_rdata_o, 0);
    step(); step(); rst_core = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg(); chk($sformatf("rs_norv%0d", i), obi_rvalid_o, 0);
      step();
    end
    obi_req_i = 1'b1; obi_addr_i = 32'h600;
    neg(); chk("rs_gnt", obi_gnt_o, 1);
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h600D600D;
    step(); wb_ack_i = 1'b0;
    neg(); chk("rs_rd", obi_rdata_o, 32'h600D600D);

    // stray ack while idle
    step(); wb_ack_i = 1'b1; wb_data_i = 32'h0BADBAD0;
    neg(); chk("sa_rv", obi_rvalid_o, 0);
    chk("sa_cyc", wb_cyc_o, 0);
    step(); neg(); chk("sa_rv2", obi_rvalid_o, 0);
    chk("sa_rdata", obi_rdata_o, 32'h600D600D);
    step(); wb_ack_i = 1'b0; obi_req_i = 1'b1; obi_addr_i = 32'h700;
    neg(); chk("sa_gnt", obi_gnt_o, 1);
    step(); obi_req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h77777777;
    step(); wb_ack_i = 1'b0;
    neg(); chk("sa_rd", obi_rdata_o, 32'h77777777);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
